alu_control_md: RTL
===================

Name: alu_control_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes Alu_op/F_Field into the 4-bit ALU Operation code, as the current datapath requires.
- Adds an iterative multiply/divide sequencer for MULT/MULTU/DIV/DIVU with HI/LO registers, MFHI/MFLO readout and a stall handshake toward the single-cycle core.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count of every mul/div.
OP_W, 4, width of the Operation output.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
Alu_op  input  2  main-control ALU class.
F_Field  input  6  instruction funct field.
valid  input  1  instruction in decode is real (not bubble/flushed).
src_a  input  WIDTH  rs operand (multiplicand/dividend).
src_b  input  WIDTH  rt operand (multiplier/divisor).
Operation  output  OP_W  ALU operation code, combinational.
illegal  output  1  R-type funct not supported, combinational.
stall  output  1  hold PC/pipeline this cycle, combinational.
md_busy  output  1  sequencer not IDLE.
md_done  output  1  one-cycle pulse, result committed.
md_result  output  WIDTH  HI for MFHI, LO for MFLO, else 0.

Behaviour:
- Decode, combinational:
  - Alu_op 00 -> ADD 0010; 01 -> SUB 0110; 11 -> OR 0001.
  - Alu_op 10 uses funct: 0x20/0x21 ADD; 0x22/0x23 SUB 0110; 0x24 AND 0000; 0x25 OR 0001; 0x27 NOR 1100; 0x2A SLT 0111.
  - Funct 0x10 MFHI, 0x12 MFLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU -> Operation ADD, illegal=0.
  - Any other funct -> ADD, illegal=valid.
- is_md = valid & Alu_op==10 & funct in {18,19,1A,1B}; is_mf = valid & Alu_op==10 & funct in {10,12}.
- Sequencer FSM, one clock domain:
  - IDLE: on is_md latch |operands| (signed ops) or raw operands, record result signs, count=0 -> RUN.
    - Divisor 0: skip RUN -> DONE with LO=all ones, HI=src_a.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; after WIDTH steps -> DONE.
  - DONE: apply sign fix; write HI/LO at the exit edge; md_done=1 for this cycle only; -> IDLE.
    - Signed sign rules: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign.
- Latency: issue sampled at edge E0; md_busy=1 for WIDTH+1 cycles; HI/LO valid from edge E(WIDTH+1). Divide-by-zero: busy 1 cycle.
- stall = md_busy & (is_md | is_mf). Unrelated instructions proceed during RUN.
  - A stalled md op is held by the core and accepted in the cycle busy drops.
- MULT HI/LO = upper/lower WIDTH bits of the 2*WIDTH product. DIV LO=quotient, HI=remainder.
- Signed DIV of most-negative / -1: LO=most-negative, HI=0; no trap.
- md_result: is_mf & !stall -> HI (0x10) or LO (0x12); else 0.
- Reset (async, any time incl. mid-RUN): FSM IDLE, HI=LO=0, count=0. Outputs md_busy=0, md_done=0, stall=0, md_result=0. The partial operation is discarded.
- valid=0 never starts an operation and never stalls.

Optional Feature:
- Macro: ALU_CTRL_DIV_EN.
- Defined: DIV/DIVU supported as above.
- Undefined: divide datapath omitted. Funct 0x1A/0x1B decode as illegal: Operation ADD, illegal=valid, sequencer not started, no stall. MULT/MULTU/MFHI/MFLO unchanged.

Decomposition:
- Package alu_ctrl_pkg: Operation code constants (AND, OR, ADD, SUB, SLT, NOR), Alu_op class constants, funct constants, FSM state enum (IDLE, RUN, DONE).
- One sub-module: md_iter_unit, the WIDTH-step shift/subtract datapath with counter.
- alu_control_md keeps decode, stall logic and HI/LO.

Test Plan:
- Decode sweep: Alu_op 00/01/11, then 10 with funct 0x20,0x22,0x24,0x25,0x27,0x2A,0x3F -> 0010,0110,0001,0010,0110,0000,0001,1100,0111, and ADD with illegal=1 for 0x3F.
- MULT src_a=-3, src_b=7, WIDTH=32 -> busy 33 cycles, md_done single pulse; then MFLO md_result=0xFFFFFFEB, MFHI=0xFFFFFFFF.
- DIVU src_a=100, src_b=7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV src_b=0, src_a=0x1234 -> busy 1 cycle, LO=0xFFFFFFFF, HI=0x1234.
- MFLO issued 5 cycles after MULTU 5*6 -> stall=1 until busy drops, then md_result=30. An ADD issued during RUN -> stall=0.
- rst_n low in RUN cycle 10 -> md_busy=0, md_result=0 immediately; after release MFHI returns 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control decoder and its multiply/divide sequencer.
package alu_ctrl_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_AND = 4'b0000;
  localparam logic [OPC_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOR = 4'b1100;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_iter_unit.sv
// WIDTH-step shift-add multiplier / restoring divider on unsigned magnitudes.
// Divide path present only when ALU_CTRL_DIV_EN is defined.
module md_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef ALU_CTRL_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum_c;

  assign last_c = (count_q == CNT_W'(WIDTH - 1));

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign sum_c = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);

`ifdef ALU_CTRL_DIV_EN
  logic [WIDTH:0] rem_sh_c;
  logic [WIDTH:0] diff_c;

  // Divide: shift next dividend bit into the partial remainder and try the subtract.
  assign rem_sh_c = {hi, lo[WIDTH-1]};
  assign diff_c   = rem_sh_c - {1'b0, b_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hi      <= '0;
      lo      <= '0;
      b_q     <= '0;
    end else if (load) begin
      count_q <= '0;
      hi      <= '0;
      lo      <= a;
      b_q     <= b;
    end else if (step) begin
      count_q <= count_q + CNT_W'(1);
`ifdef ALU_CTRL_DIV_EN
      if (is_div) begin
        if (!diff_c[WIDTH]) begin
          hi <= diff_c[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= rem_sh_c[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        hi <= sum_c[WIDTH:1];
        lo <= {sum_c[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder with iterative MULT/DIV sequencer, HI/LO registers and stall handshake.
// Define ALU_CTRL_DIV_EN to include DIV/DIVU; otherwise those functs decode as illegal.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Alu_op,
  input  logic [5:0]       F_Field,
  input  logic             valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [OP_W-1:0]  Operation,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] md_result
);

  logic [OPC_W-1:0] op_c;
  logic fn_ok_c, fn_md_c, fn_mf_c, fn_div_c, fn_signed_c;
  logic is_md_c, is_mf_c;

  // Instruction decode
  always_comb begin
    op_c        = OP_ADD;
    fn_ok_c     = 1'b0;
    fn_md_c     = 1'b0;
    fn_mf_c     = 1'b0;
    fn_div_c    = 1'b0;
    fn_signed_c = 1'b0;
    case (Alu_op)
      ALU_OP_ADD: op_c = OP_ADD;
      ALU_OP_SUB: op_c = OP_SUB;
      ALU_OP_OR:  op_c = OP_OR;
      default: begin
        fn_ok_c = 1'b1;
        case (F_Field)
          FN_ADD, FN_ADDU:  op_c = OP_ADD;
          FN_SUB, FN_SUBU:  op_c = OP_SUB;
          FN_AND:           op_c = OP_AND;
          FN_OR:            op_c = OP_OR;
          FN_NOR:           op_c = OP_NOR;
          FN_SLT:           op_c = OP_SLT;
          FN_MFHI, FN_MFLO: fn_mf_c = 1'b1;
          FN_MULT: begin
            fn_md_c     = 1'b1;
            fn_signed_c = 1'b1;
          end
          FN_MULTU:         fn_md_c = 1'b1;
`ifdef ALU_CTRL_DIV_EN
          FN_DIV: begin
            fn_md_c     = 1'b1;
            fn_div_c    = 1'b1;
            fn_signed_c = 1'b1;
          end
          FN_DIVU: begin
            fn_md_c  = 1'b1;
            fn_div_c = 1'b1;
          end
`endif
          default:          fn_ok_c = 1'b0;
        endcase
      end
    endcase
  end

  assign Operation = OP_W'(op_c);
  assign illegal   = valid & (Alu_op == ALU_OP_RTYPE) & ~fn_ok_c;
  assign is_md_c   = valid & fn_md_c;
  assign is_mf_c   = valid & fn_mf_c;

  md_state_e state_q, state_d;
  logic load_c, step_c, last_c;
  logic div_q, neg_res_q, neg_rem_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_q, unit_hi, unit_lo;

  assign md_busy = (state_q != MD_IDLE);
  assign md_done = (state_q == MD_DONE);
  assign stall   = md_busy & (is_md_c | is_mf_c);

  // Operand conditioning: signed ops iterate on magnitudes; a zero divisor passes src_a through raw.
  logic a_neg_c, b_neg_c, div0_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, a_load_c;

  assign a_neg_c  = fn_signed_c & src_a[WIDTH-1];
  assign b_neg_c  = fn_signed_c & src_b[WIDTH-1];
  assign a_mag_c  = a_neg_c ? -src_a : src_a;
  assign b_mag_c  = b_neg_c ? -src_b : src_b;
  assign div0_c   = fn_div_c & (src_b == '0);
  assign a_load_c = div0_c ? src_a : a_mag_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (is_md_c) begin
          load_c  = 1'b1;
          state_d = div0_c ? MD_DONE : MD_RUN;
        end
      end
      MD_RUN: begin
        step_c = 1'b1;
        if (last_c) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (load_c) begin
      div_q     <= fn_div_c;
      neg_res_q <= a_neg_c ^ b_neg_c;
      neg_rem_q <= a_neg_c;
      div0_q    <= div0_c;
    end
  end

  md_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_c),
    .step   (step_c),
`ifdef ALU_CTRL_DIV_EN
    .is_div (div_q),
`endif
    .a      (a_load_c),
    .b      (b_mag_c),
    .last_c (last_c),
    .hi     (unit_hi),
    .lo     (unit_lo)
  );

  // Sign fix-up applied in DONE; remainder follows the dividend sign.
  logic [2*WIDTH-1:0] prod_c, prod_fix_c;
  logic [WIDTH-1:0]   hi_d, lo_d;

  assign prod_c     = {unit_hi, unit_lo};
  assign prod_fix_c = neg_res_q ? -prod_c : prod_c;

  always_comb begin
    hi_d = prod_fix_c[2*WIDTH-1:WIDTH];
    lo_d = prod_fix_c[WIDTH-1:0];
    if (div0_q) begin
      hi_d = unit_lo;
      lo_d = '1;
    end else if (div_q) begin
      hi_d = neg_rem_q ? -unit_hi : unit_hi;
      lo_d = neg_res_q ? -unit_lo : unit_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == MD_DONE) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign md_result = (is_mf_c & ~stall) ? ((F_Field == FN_MFHI) ? hi_q : lo_q) : '0;

endmodule
